// File: rtl/keypad_emu.sv
// Keypad emulator: drives row returns as if a key in a 4x3 matrix were pressed.
// Commands wait in a FIFO. Define KEYPAD_EMU_BOUNCE_EN to emulate contact bounce.
module keypad_emu #(
  parameter int FIFO_DEPTH    = 4,
  parameter int GAP_CYCLES    = 16,
  parameter int BOUNCE_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  key_col,
  output logic [3:0]  key_row,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_key,
  input  logic [15:0] cmd_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      GAP_CYCLES < 1 || BOUNCE_CYCLES < 1) begin : g_bad_params
    $error("keypad_emu: illegal parameter combination");
  end

`ifdef KEYPAD_EMU_BOUNCE_EN
  typedef enum logic [1:0] {IDLE, PRESS, GAP, BOUNCE} state_t;
  localparam logic [15:0] BOUNCE_LAST = 16'(BOUNCE_CYCLES - 1);
  logic [15:0] bounce_cnt;
`else
  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;
`endif

  logic [19:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_count;
  state_t        state;
  logic [15:0]   hold_cnt;
  logic [15:0]   gap_cnt;
  logic [1:0]    act_row;
  logic [1:0]    act_col;
  logic          contact;
  logic          push;
  logic          pop;
  logic          head_bad;
  logic [3:0]    head_key;
  logic [15:0]   head_hold;

  function automatic logic [3:0] key_to_rc(input logic [3:0] k);
    if (k < 4'd3)      return {2'd0, 2'(k)};
    else if (k < 4'd6) return {2'd1, 2'(k - 4'd3)};
    else if (k < 4'd9) return {2'd2, 2'(k - 4'd6)};
    else               return {2'd3, 2'(k - 4'd9)};
  endfunction

  assign head_key  = fifo_mem[rd_ptr][19:16];
  assign head_hold = fifo_mem[rd_ptr][15:0];
  assign head_bad  = (head_key > 4'd11) || (head_hold == 16'd0);

  // Readiness ignores a same-cycle pop, so a full FIFO always refuses for one cycle.
  assign cmd_ready = (fifo_count != FULL_COUNT);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && (fifo_count != '0);
  assign err       = pop && head_bad;
  assign busy      = (state != IDLE) || (fifo_count != '0);

`ifdef KEYPAD_EMU_BOUNCE_EN
  assign contact = (state == PRESS) || (state == BOUNCE && !bounce_cnt[0]);
`else
  assign contact = (state == PRESS);
`endif

  always_comb begin
    key_row = '0;
    if (contact && key_col[act_col])
      key_row[act_row] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= {cmd_key, cmd_hold};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Hold counts down to 1 so the full 16-bit range is usable without wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      act_row  <= '0;
      act_col  <= '0;
      done     <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
      bounce_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (pop && !head_bad) begin
            {act_row, act_col} <= key_to_rc(head_key);
            hold_cnt           <= head_hold;
`ifdef KEYPAD_EMU_BOUNCE_EN
            bounce_cnt <= '0;
            state      <= BOUNCE;
`else
            state <= PRESS;
`endif
          end
        end
        PRESS: begin
          if (hold_cnt == 16'd1) begin
            gap_cnt <= '0;
            state   <= GAP;
          end else begin
            hold_cnt <= hold_cnt - 16'd1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
`ifdef KEYPAD_EMU_BOUNCE_EN
        BOUNCE: begin
          if (bounce_cnt == BOUNCE_LAST)
            state <= PRESS;
          else
            bounce_cnt <= bounce_cnt + 16'd1;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
